// File: rtl/itof_pipe.sv
// Three-stage pipelined integer to IEEE-754 binary32 converter with a valid/ready handshake.
// Stages: magnitude extraction, leading-one normalisation, round and pack.
module itof_pipe #(
  parameter int IN_W  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_signed,
  input  logic [1:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_inexact,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = (IN_W > 2) ? $clog2(IN_W) : 1;

  logic             w_adv;
  logic             w_sign1;
  logic [IN_W-1:0]  w_mag1;

  logic             r_v1;
  logic             r_sign1;
  logic [IN_W-1:0]  r_mag1;
  logic [1:0]       r_rm1;
  logic [TAG_W-1:0] r_tag1;

  logic [PW-1:0]    w_p2;
  logic [PW-1:0]    w_shift2;
  logic [IN_W-2:0]  w_frac2;

  logic             r_v2;
  logic             r_sign2;
  logic [PW-1:0]    r_p2;
  logic [IN_W-2:0]  r_frac2;
  logic             r_zero2;
  logic [1:0]       r_rm2;
  logic [TAG_W-1:0] r_tag2;

  logic [IN_W+23:0] w_ext3;
  logic [22:0]      w_mant3;
  logic             w_g3;
  logic             w_s3;
  logic             w_up3;
  logic [23:0]      w_sum3;
  logic [7:0]       w_exp3;
  logic [31:0]      w_res3;

  logic             r_out_valid;
  logic [31:0]      r_out_data;
  logic             r_out_inexact;
  logic [TAG_W-1:0] r_out_tag;

  // A single global advance: the whole pipe freezes while a result waits.
  assign w_adv    = !r_out_valid | out_ready;
  assign in_ready = w_adv;

  assign w_sign1 = in_signed & in_data[IN_W-1];
  assign w_mag1  = w_sign1 ? -in_data : in_data;

  always_comb begin
    w_p2 = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (r_mag1[i]) w_p2 = PW'(i);
    end
  end

  // The leading one itself is implicit, so only the bits below it are kept.
  assign w_shift2 = PW'(IN_W - 1) - w_p2;
  assign w_frac2  = (IN_W-1)'(r_mag1 << w_shift2);

  assign w_ext3  = {r_frac2, 25'b0};
  assign w_mant3 = w_ext3[IN_W+23 -: 23];
  assign w_g3    = w_ext3[IN_W];
  assign w_s3    = |w_ext3[IN_W-1:0];

  always_comb begin
    w_up3 = 1'b0;
    case (r_rm2)
      2'b00:   w_up3 = w_g3 & (w_s3 | w_mant3[0]);
      2'b01:   w_up3 = 1'b0;
      2'b10:   w_up3 = !r_sign2 & (w_g3 | w_s3);
      default: w_up3 = r_sign2 & (w_g3 | w_s3);
    endcase
  end

  // A mantissa carry-out leaves the fraction all-zero and bumps the exponent.
  assign w_sum3 = {1'b0, w_mant3} + {23'b0, w_up3};
  assign w_exp3 = 8'd127 + {{(8-PW){1'b0}}, r_p2} + {7'b0, w_sum3[23]};
  assign w_res3 = r_zero2 ? 32'h0 : {r_sign2, w_exp3, w_sum3[22:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1          <= 1'b0;
      r_sign1       <= 1'b0;
      r_mag1        <= '0;
      r_rm1         <= '0;
      r_tag1        <= '0;
      r_v2          <= 1'b0;
      r_sign2       <= 1'b0;
      r_p2          <= '0;
      r_frac2       <= '0;
      r_zero2       <= 1'b0;
      r_rm2         <= '0;
      r_tag2        <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_inexact <= 1'b0;
      r_out_tag     <= '0;
    end else if (w_adv) begin
      r_v1          <= in_valid;
      r_sign1       <= w_sign1;
      r_mag1        <= w_mag1;
      r_rm1         <= in_rm;
      r_tag1        <= in_tag;
      r_v2          <= r_v1;
      r_sign2       <= r_sign1;
      r_p2          <= w_p2;
      r_frac2       <= w_frac2;
      r_zero2       <= (r_mag1 == '0);
      r_rm2         <= r_rm1;
      r_tag2        <= r_tag1;
      r_out_valid   <= r_v2;
      r_out_data    <= w_res3;
      r_out_inexact <= !r_zero2 & (w_g3 | w_s3);
      r_out_tag     <= r_tag2;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_inexact = r_out_inexact;
  assign out_tag     = r_out_tag;

endmodule

// File: tb/tb_itof_pipe.sv
// Bench for itof_pipe: three widths (16/32/64) run in lockstep from one stimulus stream,
// results checked through an in-order scoreboard against constants and a reference model.
module tb_itof_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_signed = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  in_rm = 2'd0;
  logic [3:0]  in_tag = 4'd0;
  logic [15:0] inData16 = '0;
  logic [31:0] inData32 = '0;
  logic [63:0] inData64 = '0;

  logic        inReady16, inReady32, inReady64;
  logic        outValid16, outValid32, outValid64;
  logic [31:0] outData16, outData32, outData64;
  logic        outInexact16, outInexact32, outInexact64;
  logic [3:0]  outTag16, outTag32, outTag64;

  typedef struct {
    logic [31:0] e16, e32, e64;
    logic        i16, i32, i64;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic        sgn;
    logic [1:0]  rm;
    logic [31:0] exp;
    logic        inx;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[17];
  int   nCompared = 0;
  int   nMismatched = 0;
  int   cyc = 0;
  int   stallFrom = 1000000;
  int   stallSeen = 0;

  itof_pipe #(.IN_W(16), .TAG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady16),
    .in_data(inData16), .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(outValid16), .out_ready(out_ready), .out_data(outData16),
    .out_inexact(outInexact16), .out_tag(outTag16));

  itof_pipe #(.IN_W(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady32),
    .in_data(inData32), .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(outValid32), .out_ready(out_ready), .out_data(outData32),
    .out_inexact(outInexact32), .out_tag(outTag32));

  itof_pipe #(.IN_W(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady64),
    .in_data(inData64), .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(outValid64), .out_ready(out_ready), .out_data(outData64),
    .out_inexact(outInexact64), .out_tag(outTag64));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer backpressure window, five cycles long once armed.
  always @(negedge clk) out_ready = !((cyc >= stallFrom) && (cyc < stallFrom + 5));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference conversion: integer rounding by remainder comparison against the half-ulp.
  function automatic logic [32:0] refConv(input logic [63:0] x, input int w,
                                          input logic sgn, input logic [1:0] rm);
    logic [63:0] mask, v, mag, keep, rem, half;
    logic        neg, up;
    int          e, sh;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v    = x & mask;
    neg  = sgn && v[w-1];
    mag  = neg ? ((~v + 64'd1) & mask) : v;
    if (mag == 64'd0) return 33'd0;
    e = 63;
    while (!mag[e]) e--;
    half = 64'd0;
    if (e <= 23) begin
      keep = mag << (23 - e);
      rem  = 64'd0;
    end else begin
      sh   = e - 23;
      keep = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
    end
    case (rm)
      2'b00:   up = (rem > half) || ((rem == half) && (rem != 0) && keep[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = !neg && (rem != 0);
      default: up = neg && (rem != 0);
    endcase
    keep = keep + {63'd0, up};
    if (keep[24]) begin
      keep = keep >> 1;
      e++;
    end
    return {rem != 0, neg, 8'(127 + e), keep[22:0]};
  endfunction

  function automatic exp_t makeExp(input logic [63:0] v, input logic sgn,
                                   input logic [1:0] rm, input logic [3:0] tag);
    exp_t        e;
    logic [32:0] r;
    r = refConv(v, 16, sgn, rm); e.e16 = r[31:0]; e.i16 = r[32];
    r = refConv(v, 32, sgn, rm); e.e32 = r[31:0]; e.i32 = r[32];
    r = refConv(v, 64, sgn, rm); e.e64 = r[31:0]; e.i64 = r[32];
    e.tag = tag;
    return e;
  endfunction

  task automatic applyStimulus(input logic [63:0] v, input logic sgn, input logic [1:0] rm,
                               input logic [3:0] tag, input exp_t e);
    int n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    inData16  = v[15:0];
    inData32  = v[31:0];
    inData64  = v;
    in_signed = sgn;
    in_rm     = rm;
    in_tag    = tag;
    #1;
    while (!inReady32 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!inReady32) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL accept timeout: in_ready=%0b after %0d cycles, required 1", inReady32, n);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && outValid32 && out_ready) begin
        if (sb.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL spurious result: data=0x%0h tag=%0d, required no output", outData32, outTag32);
        end else begin
          e = sb.pop_front();
          checkOutput("result32", {31'd0, outInexact32, outData32}, {31'd0, e.i32, e.e32});
          checkOutput("tag", 64'(outTag32), 64'(e.tag));
          checkOutput("result16", {30'd0, outValid16, outInexact16, outData16}, {30'd0, 1'b1, e.i16, e.e16});
          checkOutput("result64", {30'd0, outValid64, outInexact64, outData64}, {30'd0, 1'b1, e.i64, e.e64});
        end
      end
      if (rst_n && outValid32 && !out_ready) begin
        stallSeen++;
        checkOutput("in_ready during stall", {61'd0, inReady16, inReady32, inReady64}, 64'd0);
      end
    end
  end

  initial begin
    exp_t        e;
    logic [63:0] v;
    int          n;

    tbl[0]  = '{32'h00000001, 1'b1, 2'b00, 32'h3F800000, 1'b0};
    tbl[1]  = '{32'hFFFFFFFF, 1'b1, 2'b00, 32'hBF800000, 1'b0};
    tbl[2]  = '{32'h00000000, 1'b1, 2'b00, 32'h00000000, 1'b0};
    tbl[3]  = '{32'h80000000, 1'b1, 2'b00, 32'hCF000000, 1'b0};
    tbl[4]  = '{32'h80000000, 1'b1, 2'b01, 32'hCF000000, 1'b0};
    tbl[5]  = '{32'h80000000, 1'b1, 2'b10, 32'hCF000000, 1'b0};
    tbl[6]  = '{32'h80000000, 1'b1, 2'b11, 32'hCF000000, 1'b0};
    tbl[7]  = '{32'h80000000, 1'b0, 2'b00, 32'h4F000000, 1'b0};
    tbl[8]  = '{32'hFFFFFFFF, 1'b0, 2'b00, 32'h4F800000, 1'b1};
    tbl[9]  = '{32'hFFFFFFFF, 1'b0, 2'b01, 32'h4F7FFFFF, 1'b1};
    tbl[10] = '{32'hFFFFFFFF, 1'b0, 2'b10, 32'h4F800000, 1'b1};
    tbl[11] = '{32'h01000001, 1'b0, 2'b00, 32'h4B800000, 1'b1};
    tbl[12] = '{32'h01000003, 1'b0, 2'b00, 32'h4B800002, 1'b1};
    tbl[13] = '{32'h01000001, 1'b0, 2'b10, 32'h4B800001, 1'b1};
    tbl[14] = '{32'hFEFFFFFF, 1'b1, 2'b11, 32'hCB800001, 1'b1};
    tbl[15] = '{32'hFEFFFFFF, 1'b1, 2'b10, 32'hCB800000, 1'b1};
    tbl[16] = '{32'h01000001, 1'b0, 2'b01, 32'h4B800000, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", {61'd0, outValid16, outValid32, outValid64}, 64'd0);
    checkOutput("reset out_data", {outData16, outData32}, 64'd0);
    checkOutput("reset out_data64", 64'(outData64), 64'd0);
    checkOutput("reset inexact/tag", {51'd0, outInexact16, outInexact32, outInexact64, outTag16, outTag32, outTag64}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single isolated op to measure the unstalled latency.
    v = 64'd5;
    applyStimulus(v, 1'b0, 2'b00, 4'd9, makeExp(v, 1'b0, 2'b00, 4'd9));
    n = 1;
    while (!outValid32 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("latency", 64'(n), 64'd3);
    waitDrain();

    for (int i = 0; i < 17; i++) begin
      v = tbl[i].sgn ? {{32{tbl[i].d[31]}}, tbl[i].d} : {32'd0, tbl[i].d};
      e = makeExp(v, tbl[i].sgn, tbl[i].rm, 4'(i));
      e.e32 = tbl[i].exp;
      e.i32 = tbl[i].inx;
      applyStimulus(v, tbl[i].sgn, tbl[i].rm, 4'(i), e);
    end

    for (int i = 0; i < 12; i++) begin
      logic       s;
      logic [1:0] rm;
      v  = {$urandom, $urandom} >> $urandom_range(0, 60);
      s  = 1'($urandom_range(0, 1));
      rm = 2'($urandom_range(0, 3));
      applyStimulus(v, s, rm, 4'(i), makeExp(v, s, rm, 4'(i)));
    end

    v = '1;
    e = makeExp(v, 1'b0, 2'b00, 4'd15);
    e.e64 = 32'h5F800000;
    e.i64 = 1'b1;
    applyStimulus(v, 1'b0, 2'b00, 4'd15, e);
    waitDrain();

    // Eight ops back to back with the consumer stalled mid-stream.
    stallFrom = cyc + 4;
    for (int t = 0; t < 8; t++) begin
      v = {$urandom, $urandom};
      applyStimulus(v, 1'b1, 2'b00, 4'(t), makeExp(v, 1'b1, 2'b00, 4'(t)));
    end
    waitDrain();
    checkOutput("stall observed", 64'(stallSeen > 0), 64'd1);

    // Reset with three ops in flight: all must vanish.
    for (int t = 0; t < 3; t++) begin
      v = 64'(t + 100);
      applyStimulus(v, 1'b0, 2'b00, 4'(t), makeExp(v, 1'b0, 2'b00, 4'(t)));
    end
    checkOutput("in flight before reset", 64'(outValid32), 64'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("reset flush out_valid", {61'd0, outValid16, outValid32, outValid64}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("post-reset idle", {61'd0, outValid16, outValid32, outValid64}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
